contatore_gray: RTL and testbench

- Free-running N-bit Gray-code up-counter, 3 bits by default.
- Each rising clock edge out of reset advances the output to the next reflected-binary Gray code word.
- Exactly one output bit changes per step.
- Generic building block for sequencing, pointers and low-toggle-rate state encoding.
- No enable and no load: it counts every cycle while reset is low.

---
 rtl/contatore_gray_pkg.sv | 38 +++
 rtl/contatore_gray.sv | 70 +++++++
 tb/tb_contatore_gray.sv | 112 +++++++++++
 3 files changed

// File: rtl/contatore_gray_pkg.sv
// Shared constants and Gray-code helpers for contatore_gray.
package contatore_gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  // Reflected-binary encode of the low w bits of x; upper bits cleared.
  function automatic logic [15:0] bin2gray(logic [15:0] x, int w);
    logic [15:0] mask;
    mask = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 32'd1);
    return (x ^ (x >> 1)) & mask;
  endfunction

  // Gray decode: prefix XOR running from bit w-1 down to bit 0.
  function automatic logic [15:0] gray2bin(logic [15:0] g, int w);
    logic [15:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  // Number of set bits in x.
  function automatic int unsigned popcount(logic [15:0] x);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      n = n + 32'(x[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/contatore_gray.sv
// Free-running WIDTH-bit Gray-code up-counter with registered output.
// Optional self-checks are compiled when CONTATORE_GRAY_CHECK_EN is defined.
module contatore_gray
  import contatore_gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Next binary count and its Gray image, loaded together so y is a pure register.
  always_comb begin
    bin_d = bin_q + WIDTH'(1);
    y_d   = WIDTH'(bin2gray(16'(bin_d), int'(WIDTH)));
  end

  // State registers with synchronous reset taking priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      y_q   <= '0;
    end else begin
      bin_q <= bin_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

`ifdef CONTATORE_GRAY_CHECK_EN
  localparam logic [WIDTH-1:0] Y_TOP = WIDTH'(32'd1 << (WIDTH - 1));

  logic started_q;

  // Marks that a reset has been seen so checks never look at power-up values.
  always_ff @(posedge clk) begin
    if (reset) begin
      started_q <= 1'b1;
    end
  end

  // Successive counting outputs differ in exactly one bit.
  a_one_bit: assert property (@(posedge clk)
    (started_q && !$past(reset) && !$past(reset, 2)) |->
      (popcount(16'(y ^ $past(y))) == 1))
    else $error("%t one-bit step violated: prev y=%0h y=%0h", $time, $past(y), y);

  // Decoded output advances by one modulo 2**WIDTH.
  a_incr: assert property (@(posedge clk)
    (started_q && !$past(reset) && !$past(reset, 2)) |->
      (WIDTH'(gray2bin(16'(y), int'(WIDTH))) ==
       WIDTH'(gray2bin(16'($past(y)), int'(WIDTH)) + 16'd1)))
    else $error("%t increment violated: prev y=%0h y=%0h", $time, $past(y), y);

  // Output is zero right after a reset edge.
  a_reset: assert property (@(posedge clk)
    (started_q && $past(reset)) |-> (y == '0))
    else $error("%t reset value violated: prev y=%0h y=%0h", $time, $past(y), y);

  // Wrap from the top code back to zero.
  c_wrap: cover property (@(posedge clk)
    (started_q && !$past(reset) && !$past(reset, 2) && $past(y) == Y_TOP && y == '0));
`endif

endmodule

// File: tb/tb_contatore_gray.sv
// Randomized self-checking bench for contatore_gray at WIDTH 3, 4 and 1.
module tb_contatore_gray;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3, rst4, rst1;
  logic [2:0] y3;
  logic [3:0] y4;
  logic [0:0] y1;

  contatore_gray #(.WIDTH(3)) u_w3 (.clk(clk), .reset(rst3), .y(y3));
  contatore_gray #(.WIDTH(4)) u_w4 (.clk(clk), .reset(rst4), .y(y4));
  contatore_gray #(.WIDTH(1)) u_w1 (.clk(clk), .reset(rst1), .y(y1));

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference: plain binary counters per instance, Gray image by arithmetic.
  int m3 = 0, m4 = 0, m1 = 0;
  int seq3[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = g; s > 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge: advance models, then compare all instances just after the edge.
  task automatic step();
    @(posedge clk);
    m3 = rst3 ? 0 : (m3 + 1) % 8;
    m4 = rst4 ? 0 : (m4 + 1) % 16;
    m1 = rst1 ? 0 : (m1 + 1) % 2;
    #1;
    check("y3_model", 32'(y3), 32'(gray(m3)));
    check("y4_model", 32'(y4), 32'(gray(m4)));
    check("y1_model", 32'(y1), 32'(m1));
  endtask

  initial begin
    logic [2:0] prev3;

    rst3 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
    step();
    check("reset_y3", 32'(y3), 32'd0);
    check("reset_y4", 32'(y4), 32'd0);
    check("reset_y1", 32'(y1), 32'd0);

    // Two full WIDTH=3 periods against the literal sequence; WIDTH=4 full period.
    rst3 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("seq3", 32'(y3), 32'(seq3[(i + 1) % 8]));
      check("alt1", 32'(y1), 32'((i + 1) % 2));
      if (i == 14) check("w4_top", 32'(y4), 32'd8);
      if (i == 15) check("w4_wrap", 32'(y4), 32'd0);
    end

    // Reset mid-count at y=110.
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_110", 32'(y3), 32'd6);
    rst3 = 1'b1;
    step();
    check("mid_reset", 32'(y3), 32'd0);
    rst3 = 1'b0;
    step();
    check("mid_release", 32'(y3), 32'd1);

    // Reset held for five edges.
    rst3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_reset", 32'(y3), 32'd0);
    end
    rst3 = 1'b0;
    step();
    check("hold_release", 32'(y3), 32'd1);

    // Free-running: single-bit steps and decoded increment.
    for (int i = 0; i < 40; i++) begin
      prev3 = y3;
      step();
      check("one_bit", $countones(prev3 ^ y3), 32'd1);
      check("incr", 32'(g2b(int'(y3))), 32'((g2b(int'(prev3)) + 1) % 8));
    end

    // Random reset pulses on each instance independently.
    for (int i = 0; i < 300; i++) begin
      rst3 = ($urandom_range(0, 7) == 0);
      rst4 = ($urandom_range(0, 9) == 0);
      rst1 = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
